line_burst_adapter: RTL and testbench
=====================================

Name: line_burst_adapter

Overview:
Sits directly downstream of the direct-mapped write-back data cache, on its memory port. It accepts one 128-bit line read (allocate) or line write (write-back/flush) per request and serialises it into BEATS 32-bit beats on a narrow single-outstanding memory bus. Toward the cache it presents the same cen/wen/addr/wdata/rdata/stall contract that the cache already drives.

Parameters:
ADDR_W, 32, address width (byte address)
BIT_W, 32, beat width in bits; beat address stride = BIT_W/8
BEATS, 4, beats per line; power of 2, ≥2; line width LINE_W = BIT_W*BEATS
TIMEOUT_CYC, 255, per-beat wait limit; used only with BURST_TIMEOUT_EN

Ports:
i_clk  in  1  clock, all state on rising edge
i_rst  in  1  synchronous active-high reset
i_cen  in  1  line request from cache, held until stall-low cycle
i_wen  in  1  1 = line write, 0 = line read
i_addr  in  ADDR_W  line address; low log2(LINE_W/8) bits ignored, forced to 0
i_wdata  in  LINE_W  write line; word k at bits [BIT_W*k +: BIT_W]
o_rdata  out  LINE_W  read line buffer, valid in the DONE cycle
o_stall  out  1  i_cen && state!=DONE
o_bus_req  out  1  beat request valid
o_bus_we  out  1  beat is a write
o_bus_addr  out  ADDR_W  base + beat*(BIT_W/8), modulo 2^ADDR_W
o_bus_wdata  out  BIT_W  word[beat] of latched line
i_bus_gnt  in  1  beat accepted this cycle when o_bus_req=1
i_bus_rvalid  in  1  read data valid
i_bus_rdata  in  BIT_W  read beat data
o_err  out  1  timeout flag; tied 0 without BURST_TIMEOUT_EN

Behaviour:
- Reset (i_rst=1 at edge): state IDLE, beat=0, line buffer=0, latched addr/wdata/wen=0; o_bus_req=0, o_bus_we=0, o_err=0; o_stall = i_cen (combinational). Reset mid-burst aborts immediately: no further beats, no DONE pulse.
- States: IDLE, REQ, RESP, DONE.
- IDLE: if i_cen, latch aligned addr, wdata, wen; beat<=0; for reads clear line buffer; -> REQ. Else stay.
- REQ: o_bus_req=1, o_bus_we=latched wen, addr/wdata per beat. Outputs stable until i_bus_gnt. On gnt: write -> beat==BEATS-1 ? DONE : beat+1, REQ; read -> RESP.
- RESP: o_bus_req=0. On i_bus_rvalid: line[beat]<=i_bus_rdata; beat==BEATS-1 ? DONE : beat+1, REQ.
- DONE: single cycle, o_stall=0, o_rdata holds line; -> IDLE unconditionally. New request accepted in the following IDLE cycle (write-back then allocate is back-to-back).
- Minimum latency, i_cen rise to stall-low cycle: write 1+BEATS+1 = 6 cycles; read with rvalid one cycle after gnt 1+2*BEATS+1 = 10 cycles.
- Beat order ascending: word 0 at base, word BEATS-1 at base+(BEATS-1)*BIT_W/8. Address increments wrap modulo 2^ADDR_W.
- i_bus_rvalid outside RESP: ignored. i_bus_gnt with o_bus_req=0: ignored.
- i_cen deasserted mid-burst: protocol violation. Burst still completes and DONE is still entered; o_stall follows the formula.
- Line writes do not modify the line buffer. o_rdata outside DONE holds the last buffer value and is not meaningful.

Optional Feature:
BURST_TIMEOUT_EN
- Defined: 8-bit+ wait counter (clog2(TIMEOUT_CYC+1)) clears on entry to REQ or RESP and counts each cycle spent waiting in REQ/RESP. When it reaches TIMEOUT_CYC without gnt/rvalid: drop o_bus_req, go to DONE, o_err=1 for that DONE cycle only. Unreceived read words remain 0.
- Undefined: no counter; the adapter waits indefinitely; o_err constant 0.

Test Plan:
- Write line 0x44444444_33333333_22222222_11111111 @0x0000_1238, gnt always 1 -> beats at 0x1230/34/38/3C with wdata 0x11111111..0x44444444, stall low in cycle 6, o_bus_we=1 all beats.
- Read @0x0000_2000, rvalid 1 cycle after each gnt, rdata 0xA0..0xA3 -> stall low in cycle 10, o_rdata=0x000000A3_000000A2_000000A1_000000A0.
- Write-back @0x100 then cen held for read @0x300 -> second IDLE captures 0x300 the cycle after DONE, no beat lost or duplicated, 4 write beats then 4 read beats.
- gnt held low 5 cycles on beat 2 of a write -> o_bus_addr/o_bus_wdata stable during wait, total latency 11.
- Read @0xFFFF_FFF0 -> addrs 0xFFFFFFF0/F4/F8/FC, no overflow; i_rst pulsed during beat 1 -> o_bus_req=0 next cycle, state IDLE, no DONE.
- BURST_TIMEOUT_EN, TIMEOUT_CYC=8, read with no rvalid on beat 1 -> DONE after 8 wait cycles, o_err=1 one cycle, o_rdata word0=beat0 data, words1-3=0.

Source files
------------

// File: rtl/line_burst_adapter.sv
// Serialises one cache line read/write into BEATS narrow beats on a single-outstanding bus.
// Optional per-beat wait timeout is enabled by defining BURST_TIMEOUT_EN.
module line_burst_adapter #(
    parameter int ADDR_W      = 32,
    parameter int BIT_W       = 32,
    parameter int BEATS       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_cen,
    input  logic                    i_wen,
    input  logic [ADDR_W-1:0]       i_addr,
    input  logic [BIT_W*BEATS-1:0]  i_wdata,
    output logic [BIT_W*BEATS-1:0]  o_rdata,
    output logic                    o_stall,
    output logic                    o_bus_req,
    output logic                    o_bus_we,
    output logic [ADDR_W-1:0]       o_bus_addr,
    output logic [BIT_W-1:0]        o_bus_wdata,
    input  logic                    i_bus_gnt,
    input  logic                    i_bus_rvalid,
    input  logic [BIT_W-1:0]        i_bus_rdata,
    output logic                    o_err
);

    localparam int LINE_W = BIT_W * BEATS;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int STRIDE = BIT_W / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BEAT_W-1:0]   r_beat;
    logic [BEAT_W-1:0]   w_beat_nxt;
    logic [ADDR_W-1:0]   r_base;
    logic [LINE_W-1:0]   r_wdata;
    logic [LINE_W-1:0]   r_line;
    logic                r_wen;
    logic                w_last;
    logic                w_timeout;
    logic [ADDR_W-1:0]   w_addr_aligned;
    logic                w_unused_addr_lsb;

    assign w_addr_aligned    = {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign w_unused_addr_lsb = ^i_addr[OFF_W-1:0];
    assign w_last            = (r_beat == BEAT_W'(BEATS - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_base  <= '0;
            r_wdata <= '0;
            r_line  <= '0;
            r_wen   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            if (r_state == S_IDLE && i_cen) begin
                r_base  <= w_addr_aligned;
                r_wdata <= i_wdata;
                r_wen   <= i_wen;
                if (!i_wen) begin
                    r_line <= '0;
                end
            end
            if (r_state == S_RESP && i_bus_rvalid) begin
                r_line[r_beat*BIT_W +: BIT_W] <= i_bus_rdata;
            end
        end
    end

    // A beat handshake always wins over a timeout landing in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        case (r_state)
            S_IDLE: begin
                if (i_cen) begin
                    w_state_nxt = S_REQ;
                    w_beat_nxt  = '0;
                end
            end
            S_REQ: begin
                if (i_bus_gnt) begin
                    if (!r_wen) begin
                        w_state_nxt = S_RESP;
                    end else if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_beat_nxt = r_beat + BEAT_W'(1);
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_RESP: begin
                if (i_bus_rvalid) begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_REQ;
                        w_beat_nxt  = r_beat + BEAT_W'(1);
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef BURST_TIMEOUT_EN
    localparam int WAIT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [WAIT_W-1:0] r_wait;
    logic              r_err;
    logic              w_waiting;

    assign w_waiting = (r_state == S_REQ  && !i_bus_gnt) ||
                       (r_state == S_RESP && !i_bus_rvalid);
    assign w_timeout = w_waiting && (r_wait == WAIT_W'(TIMEOUT_CYC - 1));

    // Counter is zero whenever a new wait starts, so it only measures the current beat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wait <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err  <= w_timeout;
            r_wait <= (w_waiting && !w_timeout) ? r_wait + WAIT_W'(1) : '0;
        end
    end

    assign o_err = r_err;
`else
    localparam int UNUSED_TIMEOUT_CYC = TIMEOUT_CYC;

    assign w_timeout = 1'b0;
    assign o_err     = 1'b0;
`endif

    assign o_bus_req   = (r_state == S_REQ);
    assign o_bus_we    = (r_state == S_REQ) && r_wen;
    assign o_bus_addr  = r_base + ADDR_W'(r_beat) * ADDR_W'(STRIDE);
    assign o_bus_wdata = r_wdata[r_beat*BIT_W +: BIT_W];
    assign o_rdata     = r_line;
    assign o_stall     = i_cen && (r_state != S_DONE);

endmodule

// File: tb/tb_line_burst_adapter.sv
// Bench for line_burst_adapter: vector table of line transfers with a beat scoreboard,
// plus hand-written reset-abort and (with BURST_TIMEOUT_EN) timeout sequences.
module tb_line_burst_adapter;

`ifdef BURST_TIMEOUT_EN
    localparam int TCYC = 8;
`else
    localparam int TCYC = 255;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_cen;
    logic          i_wen;
    logic [31:0]   i_addr;
    logic [127:0]  i_wdata;
    logic [127:0]  o_rdata;
    logic          o_stall;
    logic          o_bus_req;
    logic          o_bus_we;
    logic [31:0]   o_bus_addr;
    logic [31:0]   o_bus_wdata;
    logic          i_bus_gnt;
    logic          i_bus_rvalid;
    logic [31:0]   i_bus_rdata;
    logic          o_err;

    line_burst_adapter #(
        .ADDR_W(32), .BIT_W(32), .BEATS(4), .TIMEOUT_CYC(TCYC)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_cen(i_cen), .i_wen(i_wen),
        .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata), .o_stall(o_stall),
        .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
        .o_bus_wdata(o_bus_wdata), .i_bus_gnt(i_bus_gnt), .i_bus_rvalid(i_bus_rvalid),
        .i_bus_rdata(i_bus_rdata), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic          wen;
        logic [31:0]   addr;
        logic [127:0]  wdata;
        int            stall_beat;
        int            stall_cyc;
        int            rv_drop;
        logic          keep;
        logic          noise;
        int            exp_lat;
        logic [127:0]  exp_line;
        logic          exp_err;
    } vec_t;

    typedef struct {
        logic          we;
        logic [31:0]   addr;
        logic [31:0]   wdata;
    } beat_t;

    vec_t          vecs[$];
    beat_t         sb[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [127:0]  last_line = '0;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return {a[31:16], 8'h00, 6'h28, a[3:2]};
    endfunction

    function automatic vec_t mk(input logic wen, input logic [31:0] addr, input logic [127:0] wd,
                                input int sb_beat, input int sb_cyc, input int rv_drop,
                                input logic keep, input logic noise, input int lat,
                                input logic [127:0] line, input logic err);
        vec_t v;
        v.wen = wen; v.addr = addr; v.wdata = wd;
        v.stall_beat = sb_beat; v.stall_cyc = sb_cyc; v.rv_drop = rv_drop;
        v.keep = keep; v.noise = noise; v.exp_lat = lat; v.exp_line = line; v.exp_err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Entered at posedge+1; drives one line request and plays the bus slave until DONE.
    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] base;
        logic [31:0] gaddr;
        logic [31:0] hold_addr;
        logic [31:0] hold_wd;
        beat_t       b;
        int          n_exp;
        int          cyc;
        int          beat;
        int          waited;
        bit          pend;
        bit          done;
        base  = v.addr & 32'hFFFF_FFF0;
        n_exp = (v.rv_drop >= 0) ? v.rv_drop + 1 : 4;
        for (int k = 0; k < n_exp; k++) begin
            sb.push_back('{we: v.wen, addr: base + 32'(4 * k), wdata: v.wdata[32*k +: 32]});
        end
        i_cen = 1'b1; i_wen = v.wen; i_addr = v.addr; i_wdata = v.wdata;
        cyc = 0; beat = 0; waited = 0; pend = 1'b0; done = 1'b0;
        gaddr = '0; hold_addr = '0; hold_wd = '0;
        while (!done && cyc < 100) begin
            cyc++;
            #1;
            if (!o_stall) begin
                check($sformatf("v%0d latency", idx), 128'(cyc), 128'(v.exp_lat));
                check($sformatf("v%0d err", idx), 128'(o_err), 128'(v.exp_err));
                if (!v.wen) last_line = v.exp_line;
                check($sformatf("v%0d rdata", idx), o_rdata, last_line);
                check($sformatf("v%0d beats left", idx), 128'(sb.size()), 128'(0));
                sb.delete();
                done = 1'b1;
                if (!v.keep) i_cen = 1'b0;
            end else if (o_bus_req) begin
                if (beat == v.stall_beat && waited < v.stall_cyc) begin
                    if (waited == 0) begin
                        hold_addr = o_bus_addr; hold_wd = o_bus_wdata;
                    end else begin
                        check($sformatf("v%0d hold addr", idx), 128'(o_bus_addr), 128'(hold_addr));
                        check($sformatf("v%0d hold wdata", idx), 128'(o_bus_wdata), 128'(hold_wd));
                    end
                    waited++;
                    i_bus_gnt = 1'b0;
                end else begin
                    i_bus_gnt = 1'b1;
                    if (sb.size() == 0) begin
                        check($sformatf("v%0d extra beat", idx), 128'(o_bus_addr), 128'hX);
                    end else begin
                        b = sb.pop_front();
                        check($sformatf("v%0d b%0d addr", idx, beat), 128'(o_bus_addr), 128'(b.addr));
                        check($sformatf("v%0d b%0d we", idx, beat), 128'(o_bus_we), 128'(b.we));
                        if (b.we) check($sformatf("v%0d b%0d wdata", idx, beat), 128'(o_bus_wdata), 128'(b.wdata));
                    end
                    gaddr = o_bus_addr;
                    pend = !v.wen && (beat != v.rv_drop);
                    beat++;
                end
                if (v.noise) begin
                    i_bus_rvalid = 1'b1; i_bus_rdata = 32'hDEAD_BEEF;
                end
            end else begin
                i_bus_gnt = v.noise;
                if (pend) begin
                    i_bus_rvalid = 1'b1; i_bus_rdata = rd_fn(gaddr); pend = 1'b0;
                end else if (v.noise) begin
                    i_bus_rvalid = 1'b1; i_bus_rdata = 32'hBAD0_BAD0;
                end
            end
            @(posedge i_clk);
            #1;
            i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = '0;
        end
        if (!done) begin
            check($sformatf("v%0d stall never dropped", idx), 128'(cyc), 128'(v.exp_lat));
            sb.delete();
            i_cen = 1'b0;
        end
        check($sformatf("v%0d err after done", idx), 128'(o_err), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_cen = 1'b0; i_wen = 1'b0; i_addr = '0; i_wdata = '0;
        i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = '0;

        vecs.push_back(mk(1'b1, 32'h0000_1238, 128'h44444444_33333333_22222222_11111111,
                          -1, 0, -1, 1'b0, 1'b0, 6, '0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0000_2000, 128'hDEAD_0000_0000_0000_0000_0000_0000_0000,
                          -1, 0, -1, 1'b0, 1'b1, 10, 128'h000000A3_000000A2_000000A1_000000A0, 1'b0));
        vecs.push_back(mk(1'b1, 32'h0000_0100, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000,
                          -1, 0, -1, 1'b1, 1'b0, 6, '0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0000_0300, '0,
                          -1, 0, -1, 1'b0, 1'b0, 10, 128'h000000A3_000000A2_000000A1_000000A0, 1'b0));
        vecs.push_back(mk(1'b1, 32'h0000_5000, 128'h89ABCDEF_01234567_FEDCBA98_76543210,
                          2, 5, -1, 1'b0, 1'b1, 11, '0, 1'b0));
        vecs.push_back(mk(1'b0, 32'hFFFF_FFF7, '0,
                          -1, 0, -1, 1'b0, 1'b0, 10, 128'hFFFF00A3_FFFF00A2_FFFF00A1_FFFF00A0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0001_6010, '0,
                          0, 3, -1, 1'b0, 1'b0, 13, 128'h000100A3_000100A2_000100A1_000100A0, 1'b0));
        vecs.push_back(mk(1'b1, 32'h0000_0040, 128'h0000000D_0000000C_0000000B_0000000A,
                          3, 2, -1, 1'b0, 1'b0, 8, '0, 1'b0));
`ifdef BURST_TIMEOUT_EN
        vecs.push_back(mk(1'b0, 32'h0000_4000, '0,
                          -1, 0, 1, 1'b0, 1'b0, 13, 128'h00000000_00000000_00000000_000000A0, 1'b1));
`endif

        // Reset state
        repeat (2) @(posedge i_clk);
        #1;
        check("rst bus_req", 128'(o_bus_req), 128'(0));
        check("rst bus_we", 128'(o_bus_we), 128'(0));
        check("rst err", 128'(o_err), 128'(0));
        check("rst rdata", o_rdata, '0);
        check("rst stall cen0", 128'(o_stall), 128'(0));
        i_cen = 1'b1;
        #1;
        check("rst stall cen1", 128'(o_stall), 128'(1));
        i_cen = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Reset pulsed while beat 1 of a read is being requested
        i_cen = 1'b1; i_wen = 1'b0; i_addr = 32'h0000_2000;
        @(posedge i_clk); #1;
        i_bus_gnt = 1'b1;
        @(posedge i_clk); #1;
        i_bus_gnt = 1'b0; i_bus_rvalid = 1'b1; i_bus_rdata = 32'h1111_2222;
        @(posedge i_clk); #1;
        i_bus_rvalid = 1'b0;
        #1;
        check("abort pre req", 128'(o_bus_req), 128'(1));
        check("abort pre addr", 128'(o_bus_addr), 128'h2004);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        #1;
        check("abort bus_req", 128'(o_bus_req), 128'(0));
        check("abort stall (not DONE)", 128'(o_stall), 128'(1));
        check("abort rdata cleared", o_rdata, '0);
        i_cen = 1'b0;
        last_line = '0;
        for (int k = 0; k < 3; k++) begin
            i_bus_gnt = 1'b1;
            @(posedge i_clk); #1;
            i_bus_gnt = 1'b0;
            #1;
            check($sformatf("abort idle req c%0d", k), 128'(o_bus_req), 128'(0));
        end
        @(posedge i_clk); #1;
        run_vec(mk(1'b0, 32'h0000_2000, '0, -1, 0, -1, 1'b0, 1'b0, 10,
                   128'h000000A3_000000A2_000000A1_000000A0, 1'b0), 99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
